rc4_prga_decrypt_param: RTL
===========================

// Module: rc4_prga_decrypt_param
// PURPOSE
// Parametrised RC4 PRGA decrypt engine: the successor to the fixed 32-byte decrypt FSM.
// Runs after KSA has filled S[0..255]; generates keystream, swaps S, XORs ciphertext, writes plaintext.
// Dedicated S / ciphertext / plaintext ports (no shared mux), configurable read latency,
// runtime message length, selectable plaintext check with early abort, busy/done/pass status.
// PARAMETERS
// MAX_MSG    32  max message bytes; LEN_W = $clog2(MAX_MSG+1), K_W = $clog2(MAX_MSG)
// RD_LAT     2   cycles from address presented to read data valid (S and ciphertext memories)
// CHECK_MODE 1   0 = no check; 1 = 'a'..'z' or 0x20; 2 = printable 0x20..0x7E
// PORTS
// clk       in   1      clock, all state on rising edge
// reset_n   in   1      async active-low reset
// start     in   1      begin decrypt; sampled in IDLE/DONE only
// msg_len   in   LEN_W  bytes to decrypt, latched on accepted start; 0..MAX_MSG
// s_addr    out  8      S memory address
// s_wdata   out  8      S write data
// s_wen     out  1      S write enable
// s_rdata   in   8      S read data
// ct_addr   out  K_W    ciphertext ROM address
// ct_rdata  in   8      ciphertext read data
// pt_addr   out  K_W    plaintext RAM address
// pt_wdata  out  8      plaintext write data
// pt_wen    out  1      plaintext write enable
// busy      out  1      high from accepted start until DONE entered
// done      out  1      level; high in DONE until next accepted start
// pass      out  1      valid with done: 1 = all bytes passed check (always 1 if CHECK_MODE=0)
// fail_idx  out  K_W    index k of first failing byte; 0 when pass=1
// BEHAVIOUR
// - reset_n low: state IDLE, i=j=k=0, all outputs 0 (incl. done, pass, busy, both wens).
// - States: IDLE, INC_I, RD_SI, ADD_J, RD_SJ, WR_SI, WR_SJ, RD_F, RD_CT, WR_PT, DONE.
// - IDLE/DONE + start: latch msg_len, clear i,j,k,done,pass,fail_idx -> INC_I; msg_len=0 -> DONE, pass=1.
// - start while busy: ignored.
// - INC_I: i<=i+1 (mod 256).
// - RD_* states: each lasts RD_LAT+1 cycles; address held the whole time; data sampled on the last cycle.
//   - RD_SI samples si.
//   - RD_SJ samples sj.
//   - RD_F addresses (si+sj) mod 256 and samples f.
//   - RD_CT addresses k and samples c.
// - ADD_J: j<=j+si (mod 256).
// - WR_SI: S[i]<=sj, one cycle. WR_SJ: S[j]<=si, one cycle. i==j is legal; the same value is written twice.
// - WR_PT: pt_addr=k, pt_wdata=f^c, pt_wen=1 for one cycle; the byte is written before it is checked.
// - WR_PT exit:
//   - check fails: fail_idx<=k, pass<=0 -> DONE (abort).
//   - else if k==msg_len-1: pass<=1 -> DONE.
//   - else k<=k+1 -> INC_I.
// - Moore outputs: s_*/ct_addr/pt_* are combinational from state and registers; s_wen/pt_wen are 0 outside WR_*.
// - Throughput: 9+4*RD_LAT cycles per byte (17 at RD_LAT=2). done rises one cycle after the last WR_PT.
// - DONE: all address/enable outputs 0; busy=0. S is left permuted; KSA must rerun before a new key.
// - reset_n mid-run: immediate return to IDLE; partially written S/plaintext are not restored.
// TESTING
// - S identity, ct[0]=0x63, msg_len=1: S[2] read (f=2), pt[0]=0x61, done=1, pass=1, 17 cycles after start.
// - S identity, msg_len=2, ct={0x63,0x66}: byte 1 swaps S[2]=3,S[3]=2; f=S[5]=5; pt[1]=0x63.
// - CHECK_MODE=1, S identity, ct[0]=0x43: pt[0]=0x41 written; done=1, pass=0, fail_idx=0; no further pt_wen.
// - msg_len=MAX_MSG=32, chosen key: all 32 pt bytes match golden C model; k wraps nowhere; pass=1.
// - start pulsed in mid-run: no effect. reset_n low during RD_SJ: all outputs 0 next cycle; restart gives correct result.
// - RD_LAT=1 and RD_LAT=3 builds: same plaintext as RD_LAT=2; per-byte cycle count is 13 and 21 respectively.

Source files
------------

// File: rtl/rc4_prga_decrypt_param.sv
// RC4 PRGA decrypt engine: walks an already-keyed S box, XORs keystream with ciphertext
// and writes plaintext, optionally checking each byte and aborting on the first bad one.
module rc4_prga_decrypt_param #(
  parameter int MAX_MSG    = 32,
  parameter int RD_LAT     = 2,
  parameter int CHECK_MODE = 1,
  localparam int LEN_W     = $clog2(MAX_MSG + 1),
  localparam int K_W       = $clog2(MAX_MSG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic [7:0]       s_addr,
  output logic [7:0]       s_wdata,
  output logic             s_wen,
  input  logic [7:0]       s_rdata,
  output logic [K_W-1:0]   ct_addr,
  input  logic [7:0]       ct_rdata,
  output logic [K_W-1:0]   pt_addr,
  output logic [7:0]       pt_wdata,
  output logic             pt_wen,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [K_W-1:0]   fail_idx
);

  localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LAT);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, ADD_J, RD_SJ, WR_SI, WR_SJ, RD_F, RD_CT, WR_PT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       i_q, i_d, j_q, j_d;
  logic [7:0]       si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
  logic [K_W-1:0]   k_q, k_d, fail_idx_q, fail_idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             pass_q, pass_d;
  logic             lat_last;
  logic [7:0]       pt_byte;
  logic             byte_ok;
  logic             last_byte;

  assign lat_last  = (lat_q == LAT_LAST);
  assign pt_byte   = f_q ^ c_q;
  assign last_byte = (LEN_W'(k_q) == len_q - LEN_W'(1));

  always_comb begin
    byte_ok = 1'b1;
    case (CHECK_MODE)
      1:       byte_ok = ((pt_byte >= 8'h61) && (pt_byte <= 8'h7A)) || (pt_byte == 8'h20);
      2:       byte_ok = (pt_byte >= 8'h20) && (pt_byte <= 8'h7E);
      default: byte_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      f_q        <= '0;
      c_q        <= '0;
      len_q      <= '0;
      lat_q      <= '0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      f_q        <= f_d;
      c_q        <= c_d;
      len_q      <= len_d;
      lat_q      <= lat_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // start is a plain request level with no ready: it is only looked at in IDLE/DONE,
  // so a pulse while busy is dropped. Read states hold their address RD_LAT+1 cycles
  // and capture read data on the final cycle (lat_q == RD_LAT).
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    si_d       = si_q;
    sj_d       = sj_q;
    f_d        = f_q;
    c_d        = c_q;
    len_d      = len_q;
    lat_d      = '0;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    s_addr     = '0;
    s_wdata    = '0;
    s_wen      = 1'b0;
    ct_addr    = '0;
    pt_addr    = '0;
    pt_wdata   = '0;
    pt_wen     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d      = msg_len;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          if (msg_len == '0) begin
            pass_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = INC_I;
          end
        end
      end
      INC_I: begin
        i_d     = i_q + 8'd1;
        state_d = RD_SI;
      end
      RD_SI: begin
        s_addr = i_q;
        if (lat_last) begin
          si_d    = s_rdata;
          state_d = ADD_J;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      ADD_J: begin
        j_d     = j_q + si_q;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        s_addr = j_q;
        if (lat_last) begin
          sj_d    = s_rdata;
          state_d = WR_SI;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      WR_SI: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wen   = 1'b1;
        state_d = WR_SJ;
      end
      WR_SJ: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wen   = 1'b1;
        state_d = RD_F;
      end
      RD_F: begin
        s_addr = si_q + sj_q;
        if (lat_last) begin
          f_d     = s_rdata;
          state_d = RD_CT;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      RD_CT: begin
        ct_addr = k_q;
        if (lat_last) begin
          c_d     = ct_rdata;
          state_d = WR_PT;
        end else begin
          lat_d = lat_q + CNT_W'(1);
        end
      end
      WR_PT: begin
        pt_addr  = k_q;
        pt_wdata = pt_byte;
        pt_wen   = 1'b1;
        if (!byte_ok) begin
          fail_idx_d = k_q;
          pass_d     = 1'b0;
          state_d    = DONE;
        end else if (last_byte) begin
          pass_d  = 1'b1;
          state_d = DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = INC_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;

endmodule
